// File: rtl/scarv_cop_pmul_seq.sv
// scarv_cop_pmul_seq
// Sequential packed multiplier for the SCARV coprocessor. Every lane of the
// selected width (32/16/8/4/2 bits) runs one shift-add step per cycle in
// parallel. Integer mode borrows the shared packed adder for the lane sums.
// Carry-less mode replaces the add with XOR and leaves the adder idle.
//
// Handshake: the requester raises valid and holds the operands and mode bits
// stable. ready pulses for exactly one cycle (DONE) with the result. Dropping
// valid while BUSY abandons the operation, and no ready pulse follows.
// A valid still high in the IDLE cycle after DONE starts a new operation.
module scarv_cop_pmul_seq (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  output logic        ready,
  input  logic        mul_l,
  input  logic        mul_h,
  input  logic        clmul,
  input  logic [4:0]  pw,
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  output logic [31:0] result,
  output logic [31:0] padd_lhs,
  output logic [31:0] padd_rhs,
  output logic [4:0]  padd_pw,
  output logic        padd_sub,
  input  logic [31:0] padd_carry,
  input  logic [31:0] padd_result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic [31:0] mlr;
  logic [31:0] mlr_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;

  logic        pw_onehot;
  logic [4:0]  w_last;     // lane width minus one, also the final step count
  logic [31:0] mcand;      // crs1 lanes gated by each lane's multiplier LSB
  logic [31:0] lane_sum;   // per-lane sum s
  logic [31:0] step_acc;
  logic [31:0] step_mlr;

  // Lane width decode; a non-one-hot pw is flagged so the request can be
  // completed with a zero result instead of being stepped.
  always_comb begin
    pw_onehot = (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0);
    case (pw)
      5'b00001: w_last = 5'd31;
      5'b00010: w_last = 5'd15;
      5'b00100: w_last = 5'd7;
      5'b01000: w_last = 5'd3;
      5'b10000: w_last = 5'd1;
      default:  w_last = 5'd0;
    endcase
  end

  // Multiplicand gating: each bit takes the multiplier LSB of its own lane,
  // whose index is the bit index with the in-lane offset cleared.
  always_comb begin
    mcand = 32'd0;
    for (int i = 0; i < 32; i++) begin
      int base;
      base     = i & ~int'(w_last);
      mcand[i] = crs1[i] & mlr[base];
    end
  end

  // Lane sum: shared adder result in integer mode, XOR in carry-less mode.
  always_comb begin
    lane_sum = clmul ? (acc ^ mcand) : padd_result;
  end

  // One shift-add step for every lane. The lane MSB of acc receives the lane
  // carry; every other bit shifts down within the lane. The lane MSB of mlr
  // receives the bit shifted out of the sum, so no data crosses lanes.
  always_comb begin
    logic [32:0] sum_ext;
    logic [32:0] mlr_ext;
    step_acc = 32'd0;
    step_mlr = 32'd0;
    sum_ext  = {1'b0, lane_sum};
    mlr_ext  = {1'b0, mlr};
    for (int i = 0; i < 32; i++) begin
      int   base;
      logic is_msb;
      base   = i & ~int'(w_last);
      is_msb = ((i & int'(w_last)) == int'(w_last));
      if (is_msb) begin
        step_acc[i] = clmul ? 1'b0 : padd_carry[i];
        step_mlr[i] = lane_sum[base];
      end else begin
        step_acc[i] = sum_ext[i+1];
        step_mlr[i] = mlr_ext[i+1];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= S_IDLE;
      acc   <= 32'd0;
      mlr   <= 32'd0;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      mlr   <= mlr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mlr_nxt   = mlr;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (valid) begin
          acc_nxt = 32'd0;
          cnt_nxt = 5'd0;
          if (pw_onehot) begin
            mlr_nxt   = crs2;
            state_nxt = S_BUSY;
          end else begin
            mlr_nxt   = 32'd0;
            state_nxt = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (!valid) begin
          state_nxt = S_IDLE;
        end else begin
          acc_nxt = step_acc;
          mlr_nxt = step_mlr;
          cnt_nxt = cnt + 5'd1;
          if (cnt == w_last) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs: result only while DONE, adder operands only while stepping in
  // integer mode so the shared adder sees zeros otherwise.
  always_comb begin
    ready     = (state == S_DONE);
    result    = 32'd0;
    if (state == S_DONE) begin
      if (mul_h)      result = acc;
      else if (mul_l) result = mlr;
    end
    padd_lhs  = (state == S_BUSY && !clmul) ? acc   : 32'd0;
    padd_rhs  = (state == S_BUSY && !clmul) ? mcand : 32'd0;
    padd_pw   = pw;
    padd_sub  = 1'b0;
    dbg_state = state;
  end

endmodule

// File: tb/tb_scarv_cop_pmul_seq.sv
// Testbench for scarv_cop_pmul_seq: models the shared packed adder, drives
// directed and random multiply requests, and scores results and latency
// against a per-lane reference product.
module tb_scarv_cop_pmul_seq;

  logic        g_clk;
  logic        g_reset;
  logic        valid;
  logic        ready;
  logic        mul_l;
  logic        mul_h;
  logic        clmul;
  logic [4:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;
  logic [31:0] padd_lhs;
  logic [31:0] padd_rhs;
  logic [4:0]  padd_pw;
  logic        padd_sub;
  logic [31:0] padd_carry;
  logic [31:0] padd_result;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;

  scarv_cop_pmul_seq dut (
    .g_clk       (g_clk),
    .g_reset     (g_reset),
    .valid       (valid),
    .ready       (ready),
    .mul_l       (mul_l),
    .mul_h       (mul_h),
    .clmul       (clmul),
    .pw          (pw),
    .crs1        (crs1),
    .crs2        (crs2),
    .result      (result),
    .padd_lhs    (padd_lhs),
    .padd_rhs    (padd_rhs),
    .padd_pw     (padd_pw),
    .padd_sub    (padd_sub),
    .padd_carry  (padd_carry),
    .padd_result (padd_result),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  // Packed ripple adder model: carry restarts at every lane boundary.
  int   am_w;
  logic am_cy;
  always_comb begin
    padd_result = 32'd0;
    padd_carry  = 32'd0;
    case (padd_pw)
      5'b00010: am_w = 16;
      5'b00100: am_w = 8;
      5'b01000: am_w = 4;
      5'b10000: am_w = 2;
      default:  am_w = 32;
    endcase
    am_cy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i % am_w == 0) am_cy = 1'b0;
      padd_result[i] = padd_lhs[i] ^ padd_rhs[i] ^ am_cy;
      am_cy = (padd_lhs[i] & padd_rhs[i]) | (padd_lhs[i] & am_cy) | (padd_rhs[i] & am_cy);
      padd_carry[i] = am_cy;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lane_width(input logic [4:0] p);
    case (p)
      5'b00001: return 32;
      5'b00010: return 16;
      5'b00100: return 8;
      5'b01000: return 4;
      5'b10000: return 2;
      default:  return 0;
    endcase
  endfunction

  // Reference: full 2w-bit product per lane, then select the wanted half.
  function automatic logic [31:0] ref_pmul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] p, input logic cl,
                                           input logic mh, input logic ml);
    int w;
    logic [63:0] av, bv, prod;
    logic [31:0] r;
    r = 32'd0;
    w = lane_width(p);
    if (w == 0 || (!mh && !ml)) return 32'd0;
    for (int l = 0; l < 32 / w; l++) begin
      av = 64'd0;
      bv = 64'd0;
      for (int j = 0; j < w; j++) begin
        av[j] = a[l*w+j];
        bv[j] = b[l*w+j];
      end
      if (cl) begin
        prod = 64'd0;
        for (int j = 0; j < w; j++) if (bv[j]) prod = prod ^ (av << j);
      end else begin
        prod = av * bv;
      end
      for (int j = 0; j < w; j++) r[l*w+j] = mh ? prod[w+j] : prod[j];
    end
    return r;
  endfunction

  // Driver: present one request, score result and latency, then confirm the
  // ready pulse is a single cycle.
  task automatic run_op(input string tag, input logic [4:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic h, input logic l, input logic cl);
    int   cyc;
    int   exp_cyc;
    logic got;
    logic padd_nz;
    exp_q.push_back(ref_pmul(a, b, p, cl, h, l));
    exp_cyc = (lane_width(p) == 0) ? 1 : lane_width(p) + 1;
    pw = p; crs1 = a; crs2 = b; mul_h = h; mul_l = l; clmul = cl; valid = 1'b1;
    cyc = 0; got = 1'b0; padd_nz = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge g_clk); #1;
      cyc++;
      if (cl && ((padd_lhs | padd_rhs) != 32'd0)) padd_nz = 1'b1;
      if (ready) begin
        got = 1'b1;
        check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_res"}, result, exp_q.pop_front());
        check({tag, "_sub"}, {31'd0, padd_sub}, 32'd0);
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    valid = 1'b0;
    if (cl) check({tag, "_padd_zero"}, {31'd0, padd_nz}, 32'd0);
    @(posedge g_clk); #1;
    check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  // Count ready pulses over a window with valid low.
  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge g_clk); #1;
      if (ready) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [4:0] rp;
    n_checks = 0;
    n_errors = 0;
    g_reset = 1'b1; valid = 1'b0; mul_l = 1'b0; mul_h = 1'b0; clmul = 1'b0;
    pw = 5'b00001; crs1 = 32'd0; crs2 = 32'd0;
    repeat (3) @(posedge g_clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    g_reset = 1'b0;
    @(posedge g_clk); #1;
    check("idle_padd_lhs", padd_lhs, 32'd0);

    // directed vectors
    run_op("w32_lo", 5'b00001, 32'h00000003, 32'h00000005, 1'b0, 1'b1, 1'b0);
    check("w32_lo_val", result, 32'd0);  // result back to 0 outside DONE
    run_op("w32_hi", 5'b00001, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b0);
    run_op("ff_hi", 5'b00001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op("ff_lo", 5'b00001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    run_op("w8_lo", 5'b00100, 32'h02FF10FF, 32'h03FF10FF, 1'b0, 1'b1, 1'b0);
    run_op("w8_hi", 5'b00100, 32'h02FF10FF, 32'h03FF10FF, 1'b1, 1'b0, 1'b0);
    run_op("cl16_lo", 5'b00010, 32'h00030007, 32'h00030007, 1'b0, 1'b1, 1'b1);
    run_op("cl16_hi", 5'b00010, 32'h00030007, 32'h00030007, 1'b1, 1'b0, 1'b1);
    run_op("w2_hi", 5'b10000, 32'hFFFFFFFF, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b0);
    run_op("none_sel", 5'b01000, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0);
    run_op("bad_pw", 5'b00011, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b0);

    // random requests across widths and modes
    for (int k = 0; k < 12; k++) begin
      rp = 5'(1 << $urandom_range(0, 4));
      run_op($sformatf("rnd%0d", k), rp, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end

    // abort by dropping valid in BUSY, then recover
    pw = 5'b00001; crs1 = 32'h0000FFFF; crs2 = 32'h0000FFFF;
    mul_l = 1'b1; mul_h = 1'b0; clmul = 1'b0; valid = 1'b1;
    repeat (3) begin @(posedge g_clk); #1; end
    valid = 1'b0;
    @(posedge g_clk); #1;
    check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("abort_ready", {31'd0, ready}, 32'd0);
    expect_quiet("abort_quiet", 36);
    run_op("recover", 5'b01000, 32'h00000007, 32'h00000003, 1'b0, 1'b1, 1'b0);

    // asynchronous reset in BUSY
    pw = 5'b00001; crs1 = 32'hDEADBEEF; crs2 = 32'h12345678;
    mul_h = 1'b1; mul_l = 1'b0; clmul = 1'b0; valid = 1'b1;
    repeat (4) begin @(posedge g_clk); #1; end
    #2;
    g_reset = 1'b1;
    valid = 1'b0;
    #1;
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    expect_quiet("arst_quiet", 40);
    run_op("pw_zero", 5'b00000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
